// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and default word width.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts sampled data bits of one word; done flags the increment that completes the word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  assign done = inc && (count == LAST);

  // Wraps to zero only on the completing increment, so count never exceeds WIDTH.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready holding register.
// Optional even-parity bit after each word when PARITY_CHECK_EN is defined.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b_in,
  input  logic             b_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             par_err
);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next, word;
  logic             shift_en, cnt_done, commit, drop;

  // The parity bit is not a data bit: it neither shifts nor counts.
  assign shift_en   = b_valid && (state != S_PAR);
  assign shreg_next = {b_in, shreg[WIDTH-1:1]};
  assign drop       = commit && out_valid && !out_ready;

  sipo_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk  (clk),
    .clr  (rst),
    .inc  (shift_en),
    .done (cnt_done)
  );

`ifdef PARITY_CHECK_EN
  logic par_fail;

  function automatic logic parity_ok(input logic [WIDTH-1:0] w, input logic p);
    return ~(^{w, p});
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    word       = shreg_next;
    case (state)
      S_IDLE:  if (b_valid) state_next = S_SHIFT;
`ifdef PARITY_CHECK_EN
      S_SHIFT: if (cnt_done) state_next = S_PAR;
`else
      S_SHIFT: if (cnt_done) state_next = S_IDLE;
`endif
      S_PAR:   if (b_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef PARITY_CHECK_EN
    par_fail = 1'b0;
    word     = shreg;
    if ((state == S_PAR) && b_valid) begin
      commit   = parity_ok(shreg, b_in);
      par_fail = !commit;
    end
`else
    commit = cnt_done;
`endif
  end

  // A commit refills the holding register in the same edge it is consumed; a commit
  // into an unconsumed register is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (shift_en) shreg <= shreg_next;
      if (commit && !drop) begin
        data_out  <= word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else if (par_fail) par_err <= 1'b1;
    else if (clr_err) par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: hand-expected vector table, then random traffic against a queue-based model.
module tb_sipo_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, b_in, b_valid, out_ready, clr_err;
  logic [W-1:0] data_out;
  logic         out_valid, overrun, par_err;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .b_in      (b_in),
    .b_valid   (b_valid),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         b, v, rdy, clr, rs;
    logic         ev;
    logic [W-1:0] ed;
    logic         eo, ep, cd;
    string        tag;
  } vec_t;

  vec_t  tbl[$];
  string cur_tag;
  int    errors = 0;
  int    checks = 0;

  task automatic add(input logic b, v, rdy, clr, rs, ev, input logic [W-1:0] ed,
                     input logic eo, ep, cd);
    vec_t r;
    r.b = b; r.v = v; r.rdy = rdy; r.clr = clr; r.rs = rs;
    r.ev = ev; r.ed = ed; r.eo = eo; r.ep = ep; r.cd = cd; r.tag = cur_tag;
    tbl.push_back(r);
  endtask

  // One word (plus its even-parity bit when enabled); every row but the last expects
  // the "pre" outputs, the last expects the "fin" outputs. Optional 3-cycle gap.
  task automatic push_word(input logic [W-1:0] w, input logic rdy, input int gap_at,
                           input logic pv, input logic [W-1:0] pd, input logic po,
                           input logic fv, input logic [W-1:0] fd, input logic fo,
                           input logic clr_last);
    logic bits[$];
    int   n;
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef PARITY_CHECK_EN
    bits.push_back(^w);
`endif
    n = bits.size();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) add(bits[i], 1'b1, rdy, clr_last, 1'b0, fv, fd, fo, 1'b0, fv);
      else            add(bits[i], 1'b1, rdy, 1'b0, 1'b0, pv, pd, po, 1'b0, pv);
      if (i == gap_at)
        repeat (3) add(1'b1, 1'b0, rdy, 1'b0, 1'b0, pv, pd, po, 1'b0, pv);
    end
  endtask

  task automatic consume();
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic b, v, rdy, clr, rs);
    b_in = b; b_valid = v; out_ready = rdy; clr_err = clr; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input int idx, input logic ev,
                         input logic [W-1:0] ed, input logic eo, ep, cd);
    checks++;
    if (out_valid !== ev || overrun !== eo || par_err !== ep || (cd && data_out !== ed)) begin
      errors++;
      $display("FAIL %s #%0d: got valid=%b data=%h overrun=%b par_err=%b, expected valid=%b data=%h(chk=%b) overrun=%b par_err=%b",
               tag, idx, out_valid, data_out, overrun, par_err, ev, ed, cd, eo, ep);
    end
  endtask

  // Reference model: collects sampled bits in a queue and rebuilds the word arithmetically.
  logic         bq[$];
  logic         m_v, m_o, m_p;
  logic [W-1:0] m_d;

  task automatic model_step(input logic b, v, rdy, clr, rs);
    logic         done, good, ovr_evt;
    logic [W-1:0] wd;
    int           need, ones;
    if (rs) begin
      bq.delete(); m_v = 0; m_d = '0; m_o = 0; m_p = 0;
      return;
    end
    need = W;
`ifdef PARITY_CHECK_EN
    need = W + 1;
`endif
    done = 0; good = 0; wd = '0; ones = 0;
    if (v) begin
      bq.push_back(b);
      if (bq.size() == need) begin
        done = 1;
        for (int i = 0; i < W; i++) wd = wd + (W'(bq[i]) << i);
        for (int i = 0; i < need; i++) ones += int'(bq[i]);
        good = (ones % 2 == 0) || (need == W);
        bq.delete();
      end
    end
    ovr_evt = done && good && m_v && !rdy;
    if (m_v && rdy) m_v = 0;
    if (done && good && !ovr_evt) begin m_v = 1; m_d = wd; end
    if (ovr_evt) m_o = 1; else if (clr) m_o = 0;
    if (done && !good) m_p = 1; else if (clr) m_p = 0;
  endtask

  initial begin
    b_in = 0; b_valid = 0; out_ready = 0; clr_err = 0; rst = 1;

    cur_tag = "reset";
    repeat (2) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    cur_tag = "a5_basic";
    push_word(8'hA5, 1'b0, -1, 1'b0, '0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (2) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    consume();

    cur_tag = "a5_gap";
    push_word(8'hA5, 1'b0, 3, 1'b0, '0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    consume();

    cur_tag = "b2b_3c_c3";
    push_word(8'h3C, 1'b1, -1, 1'b0, '0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    push_word(8'hC3, 1'b1, -1, 1'b0, '0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    consume();

    cur_tag = "overrun";
    push_word(8'h11, 1'b0, -1, 1'b0, '0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    push_word(8'h22, 1'b0, -1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    cur_tag = "ovr_vs_clr";
    push_word(8'h33, 1'b0, -1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    consume();

    cur_tag = "partial_rst";
    repeat (3) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    push_word(8'h5A, 1'b0, -1, 1'b0, '0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    consume();

`ifdef PARITY_CHECK_EN
    cur_tag = "parity_good";
    push_word(8'hA5, 1'b0, -1, 1'b0, '0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    consume();
    cur_tag = "parity_bad";
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] a5;
      a5 = 8'hA5;
      add(a5[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].b, tbl[i].v, tbl[i].rdy, tbl[i].clr, tbl[i].rs);
      compare(tbl[i].tag, i, tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ep, tbl[i].cd);
    end

    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    compare("rand_rst", 0, m_v, m_d, m_o, m_p, 1'b1);
    for (int i = 1; i <= 1500; i++) begin
      logic b, v, rdy, clr, rs;
      b   = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 99) < 75);
      rdy = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 6);
      rs  = ($urandom_range(0, 999) < 4);
      model_step(b, v, rdy, clr, rs);
      drive(b, v, rdy, clr, rs);
      compare("random", i, m_v, m_d, m_o, m_p, m_v | rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
